// File: rtl/univ_shift_register.sv
// univ_shift_register: N-bit universal shift register with parallel load,
// free-running single-step shifts and counted multi-step shifts.
// Shift kinds: logical (serial-in), rotate, and arithmetic.
// Optional feature macro: USR_ARITH_EN. When it is defined, mode 2'b10 is an
// arithmetic shift. When it is undefined, mode 2'b10 behaves as a logical
// shift and no sign-replication path is built.
module univ_shift_register #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [N-1:0]  qin,
  input  logic          shQ,
  input  logic          start,
  input  logic [CW-1:0] cnt,
  input  logic          dir,
  input  logic [1:0]    mode,
  input  logic          sin,
  output logic [N-1:0]  qout,
  output logic          sout,
  output logic          busy,
  output logic          done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state_reg;
  logic [N-1:0]  q_reg;
  logic [CW-1:0] count_reg;   // steps still to perform in a counted shift
  logic          dir_reg;     // direction captured when the counted shift starts
  logic [1:0]    mode_reg;    // mode captured when the counted shift starts
  logic          done_reg;

  logic          active_dir;
  logic [N-1:0]  step_live;
  logic [N-1:0]  step_latched;

  // One shift position. Only the bit entering the register differs between
  // modes. Reserved mode 2'b11 falls into the logical (serial-in) default.
  function automatic logic [N-1:0] shift_step(
    input logic [N-1:0] q,
    input logic         d,
    input logic [1:0]   m,
    input logic         s
  );
    logic fill;
    if (d == 1'b0) begin
      case (m)
        2'b01:   fill = q[0];
`ifdef USR_ARITH_EN
        2'b10:   fill = q[N-1];
`endif
        default: fill = s;
      endcase
      shift_step = {fill, q[N-1:1]};
    end else begin
      case (m)
        2'b01:   fill = q[N-1];
`ifdef USR_ARITH_EN
        2'b10:   fill = 1'b0;
`endif
        default: fill = s;
      endcase
      shift_step = {q[N-2:0], fill};
    end
  endfunction

  // Step candidates: live controls for single steps, captured ones for counted shifts
  always_comb begin
    step_live    = shift_step(q_reg, dir, mode, sin);
    step_latched = shift_step(q_reg, dir_reg, mode_reg, sin);
  end

  // Control FSM and data register; priority rst > ld > counted step > start > shQ
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      count_reg <= '0;
      dir_reg   <= 1'b0;
      mode_reg  <= 2'b00;
      done_reg  <= 1'b0;
    end else if (ld) begin
      // A load also cancels any counted shift in flight, silently.
      q_reg     <= qin;
      state_reg <= IDLE;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        SHIFT: begin
          q_reg     <= step_latched;
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end else begin
            done_reg  <= 1'b0;
          end
        end
        default: begin
          if (start) begin
            if (cnt == '0) begin
              // Zero-length request completes immediately without moving data.
              done_reg <= 1'b1;
            end else begin
              count_reg <= cnt;
              dir_reg   <= dir;
              mode_reg  <= mode;
              state_reg <= SHIFT;
              done_reg  <= 1'b0;
            end
          end else if (shQ) begin
            q_reg    <= step_live;
            done_reg <= 1'b0;
          end else begin
            done_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  assign active_dir = (state_reg == SHIFT) ? dir_reg : dir;
  assign qout       = q_reg;
  assign sout       = active_dir ? q_reg[N-1] : q_reg[0];
  assign busy       = (state_reg == SHIFT);
  assign done       = done_reg;

endmodule

// File: tb/tb_univ_shift_register.sv
// tb_univ_shift_register: randomized and directed stimulus for
// univ_shift_register, checked every cycle against a behavioural model.
module tb_univ_shift_register;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          ld;
  logic [N-1:0]  qin;
  logic          shQ;
  logic          start;
  logic [CW-1:0] cnt;
  logic          dir;
  logic [1:0]    mode;
  logic          sin;
  logic [N-1:0]  qout;
  logic          sout;
  logic          busy;
  logic          done;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [N-1:0] m_q;
  logic         m_busy;
  int           m_rem;
  logic         m_ldir;
  logic [1:0]   m_lmode;
  logic         m_done;

  univ_shift_register #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .ld(ld), .qin(qin), .shQ(shQ), .start(start),
    .cnt(cnt), .dir(dir), .mode(mode), .sin(sin), .qout(qout), .sout(sout),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic description of one shift position.
  function automatic logic [N-1:0] model_shift(input logic [N-1:0] q, input logic d,
                                               input logic [1:0] m, input logic s);
    int kind; // 0 logical, 1 rotate, 2 arithmetic
    int fill;
    int v;
    kind = (m == 2'b01) ? 1 : 0;
`ifdef USR_ARITH_EN
    if (m == 2'b10) kind = 2;
`endif
    v = int'(q);
    if (!d) begin
      fill = (kind == 1) ? (v % 2) : (kind == 2) ? (v / (1 << (N-1))) : int'(s);
      return N'((v / 2) + fill * (1 << (N-1)));
    end else begin
      fill = (kind == 1) ? (v / (1 << (N-1))) : (kind == 2) ? 0 : int'(s);
      return N'((v * 2 + fill) % (1 << N));
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model for the coming edge, clock it, then compare all outputs.
  task automatic cycle();
    if (rst) begin
      m_q = '0; m_busy = 0; m_rem = 0; m_ldir = 0; m_lmode = 0; m_done = 0;
    end else if (ld) begin
      m_q = qin; m_busy = 0; m_done = 0;
    end else if (m_busy) begin
      m_q = model_shift(m_q, m_ldir, m_lmode, sin);
      m_rem = m_rem - 1;
      m_done = (m_rem == 0);
      m_busy = (m_rem != 0);
    end else if (start) begin
      if (cnt == 0) begin
        m_done = 1;
      end else begin
        m_rem = int'(cnt); m_ldir = dir; m_lmode = mode; m_busy = 1; m_done = 0;
      end
    end else if (shQ) begin
      m_q = model_shift(m_q, dir, mode, sin); m_done = 0;
    end else begin
      m_done = 0;
    end
    @(posedge clk);
    #1;
    check("qout", int'(qout), int'(m_q));
    check("busy", int'(busy), int'(m_busy));
    check("done", int'(done), int'(m_done));
    check("sout", int'(sout),
          int'((m_busy ? m_ldir : dir) ? m_q[N-1] : m_q[0]));
  endtask

  task automatic idle_inputs();
    ld = 0; shQ = 0; start = 0; rst = 0;
  endtask

  task automatic load(input logic [N-1:0] v);
    idle_inputs(); ld = 1; qin = v; cycle(); ld = 0;
  endtask

  int busy_n;
  int done_n;

  initial begin
    rst = 1; ld = 0; qin = '0; shQ = 0; start = 0; cnt = '0;
    dir = 0; mode = 2'b00; sin = 0;
    m_q = '0; m_busy = 0; m_rem = 0; m_ldir = 0; m_lmode = 0; m_done = 0;

    // Reset state
    cycle();
    check("reset_qout", int'(qout), 0);
    check("reset_busy", int'(busy), 0);
    rst = 0;

    // Parallel load
    load(8'hA5);
    check("load_qout", int'(qout), 8'hA5);
    check("load_sout", int'(sout), 1);

    // Single-step logical right, sin 1,0,1
    load(8'h00);
    shQ = 1; dir = 0; mode = 2'b00;
    sin = 1; cycle(); check("lsr1", int'(qout), 8'h80);
    sin = 0; cycle(); check("lsr2", int'(qout), 8'h40);
    sin = 1; cycle(); check("lsr3", int'(qout), 8'hA0);
    shQ = 0; sin = 0;

    // Counted rotate left by 3
    load(8'h81);
    start = 1; cnt = 3; mode = 2'b01; dir = 1;
    busy_n = 0; done_n = 0;
    cycle(); start = 0;
    busy_n += int'(busy);
    for (int i = 0; i < 6; i++) begin
      cycle();
      busy_n += int'(busy);
      done_n += int'(done);
    end
    check("rol_qout", int'(qout), 8'h0C);
    check("rol_busy_cycles", busy_n, 3);
    check("rol_done_pulses", done_n, 1);

    // Counted arithmetic right by 2
    load(8'h90);
    start = 1; cnt = 2; mode = 2'b10; dir = 0; sin = 0;
    cycle(); start = 0;
    for (int i = 0; i < 3; i++) cycle();
`ifdef USR_ARITH_EN
    check("asr_qout", int'(qout), 8'hE4);
`else
    check("asr_qout", int'(qout), 8'h24);
`endif

    // Abort by load, and start ignored while busy
    load(8'h56);
    start = 1; cnt = 5; mode = 2'b01; dir = 0;
    cycle(); start = 0;
    cycle();
    start = 1; cnt = 1;
    cycle(); start = 0;
    check("ignored_start_qout", int'(qout), 8'h95);
    check("ignored_start_busy", int'(busy), 1);
    ld = 1; qin = 8'h3C;
    cycle(); ld = 0;
    check("abort_qout", int'(qout), 8'h3C);
    check("abort_busy", int'(busy), 0);
    done_n = int'(done);
    for (int i = 0; i < 6; i++) begin
      cycle();
      done_n += int'(done);
    end
    check("abort_no_done", done_n, 0);

    // cnt = 0
    load(8'h5A);
    start = 1; cnt = 0;
    cycle(); start = 0;
    check("cnt0_done", int'(done), 1);
    check("cnt0_qout", int'(qout), 8'h5A);
    cycle();
    check("cnt0_done_clear", int'(done), 0);

    // Reset in the middle of a counted shift
    load(8'hFF);
    start = 1; cnt = 7; mode = 2'b00; dir = 1; sin = 1;
    cycle(); start = 0;
    cycle();
    rst = 1; dir = 0;
    cycle();
    check("rst_mid_qout", int'(qout), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(done), 0);
    rst = 0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      ld    = ($urandom_range(0, 19) == 0);
      start = ($urandom_range(0, 7) == 0);
      shQ   = $urandom_range(0, 1);
      cnt   = CW'($urandom_range(0, (1 << CW) - 1));
      dir   = $urandom_range(0, 1);
      mode  = 2'($urandom_range(0, 3));
      sin   = $urandom_range(0, 1);
      qin   = N'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/univ_shift_register.md
UNIV_SHIFT_REGISTER -- requirements
Module: univ_shift_register

Interface
REQ-001 Parameters SHALL be:
- N, default 8, register width (N >= 2).
- CW, default 4, shift-count width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on the rising edge.
- rst, in, 1, synchronous active-high reset.
- ld, in, 1, parallel-load strobe.
- qin, in, N, parallel-load data.
- shQ, in, 1, single-step shift enable.
- start, in, 1, counted-shift request.
- cnt, in, CW, number of positions for a counted shift.
- dir, in, 1, 0 = right (toward bit 0), 1 = left.
- mode, in, 2, 00 = logical with sin, 01 = rotate, 10 = arithmetic, 11 = reserved (treated as 00).
- sin, in, 1, serial input bit for logical mode.
- qout, out, N, register contents.
- sout, out, 1, next bit to exit: qout[0] when the active dir is 0, qout[N-1] when it is 1.
- busy, out, 1, counted shift in progress.
- done, out, 1, one-cycle pulse when a counted shift completes.

Function
REQ-003 One shift step SHALL be:
- Right, logical: {sin, q[N-1:1]}.
- Right, rotate: {q[0], q[N-1:1]}.
- Right, arithmetic: {q[N-1], q[N-1:1]}.
- Left, logical: {q[N-2:0], sin}.
- Left, rotate: {q[N-2:0], q[N-1]}.
- Left, arithmetic: identical to left logical with sin forced to 0.
REQ-004 Per-edge priority SHALL be rst > ld > counted-shift step > start > shQ > hold.
REQ-005 ld=1 SHALL load qout<=qin at the edge; if busy, ld SHALL abort the counted shift: busy<=0, no done pulse.
REQ-006 In state IDLE with shQ=1 and start=0, the block SHALL perform one step per edge using the live dir, mode and sin.
REQ-007 FSM states SHALL be IDLE and SHIFT; busy SHALL be 1 exactly in SHIFT.
REQ-008 start=1 in IDLE with cnt=C>0 SHALL latch C, dir and mode at that edge (edge E0), enter SHIFT, and perform no shift at E0.
REQ-009 In SHIFT, each edge E1..EC SHALL perform one step with the latched dir and mode and the live sin; at EC the FSM SHALL return to IDLE with done=1 for exactly one cycle.
REQ-010 start=1 with cnt=0 SHALL leave qout unchanged, stay in IDLE, and pulse done for one cycle after E0.
REQ-011 start and shQ asserted while busy SHALL be ignored; no queuing.
REQ-012 start and shQ both asserted in IDLE: start SHALL win, and shQ SHALL be ignored.
REQ-013 sout SHALL use the latched dir while busy and the live dir otherwise.
REQ-014 Maximum counted shift SHALL be 2^CW-1 positions; counts >= N SHALL shift normally (rotate wraps; logical and arithmetic saturate to fill).

Reset
REQ-015 rst=1 at an edge SHALL set qout=0, state IDLE, busy=0, done=0, internal count=0 and latched dir/mode=0, overriding all other inputs, including mid-shift.
REQ-016 After rst is released, the block SHALL accept ld, shQ or start on the very next edge.

Configuration
REQ-017 Macro USR_ARITH_EN SHALL gate arithmetic mode.
- Defined: mode 10 behaves per REQ-003.
- Undefined: mode 10 SHALL behave as mode 00, and no sign-replication logic is synthesised.

Verification (N=8, CW=4)
REQ-018 Bench SHALL cover the following scenarios:
- Load: rst, then ld with qin=8'hA5 -> qout=8'hA5, busy=0, sout=1 (dir=0).
- Single-step logical right: shQ=1, dir=0, mode=00, sin sequence 1,0,1 from 8'h00 -> qout=8'h80, 8'h40, 8'hA0.
- Counted rotate left: qout=8'h81, start with cnt=3, mode=01, dir=1 -> busy for 3 cycles, qout=8'h0C, done pulses once.
- Counted arithmetic right with USR_ARITH_EN defined: qout=8'h90, cnt=2, mode=10, dir=0 -> qout=8'hE4; with the macro undefined and sin=0 -> qout=8'h24.
- Abort and ignore: ld with qin=8'h3C during cycle 2 of a cnt=5 shift -> qout=8'h3C, busy=0, no done; start issued while busy produces no effect.
- Boundary cases:
  - cnt=0 -> done pulse, qout unchanged.
  - rst asserted mid-shift -> all outputs 0 on the next edge.
